// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling ratio and frame-format defaults.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int OVERSAMPLE      = 16;
  localparam int DBIT_DEFAULT    = 8;
  localparam int SB_TICK_DEFAULT = 16;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter. Start bit, DBIT data bits LSB first, optional parity and stop bit(s).
// A one-entry holding buffer lets the next byte queue during a frame, so frames go out back to back.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DBIT       = DBIT_DEFAULT,
  parameter int SB_TICK    = SB_TICK_DEFAULT,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_ready,
  output logic            tx,
  output logic            tx_done_tick
);

  localparam int   BCW     = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int   SBW     = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
  localparam logic PAR_ODD = 1'(PARITY_ODD != 0);

  state_e          state_q, state_d;
  logic [3:0]      tick_cnt_q, tick_cnt_d;
  logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SBW-1:0]  sb_cnt_q, sb_cnt_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic [DBIT-1:0] buf_q, buf_d;
  logic            buf_full_q, buf_full_d;
  logic            parity_q, parity_d;
  logic            tx_q, tx_d;
  logic            tx_ready_q, tx_ready_d;
  logic            done_q, done_d;
  logic            load, consume, bit_last;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sb_cnt_d   = sb_cnt_q;
    shreg_d    = shreg_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    consume    = 1'b0;
    load       = tx_start && tx_ready_q;
    bit_last   = (tick_cnt_q == 4'(OVERSAMPLE - 1));

    if (s_tick) begin
      case (state_q)
        IDLE: begin
          tx_d    = 1'b1;
          consume = buf_full_q;
        end
        START: begin
          if (bit_last) begin
            tx_d       = shreg_q[0];
            bit_cnt_d  = '0;
            tick_cnt_d = '0;
            state_d    = DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        DATA: begin
          if (bit_last) begin
            tick_cnt_d = '0;
            shreg_d    = shreg_q >> 1;
            if (bit_cnt_q == BCW'(DBIT - 1)) begin
              if (PARITY_EN != 0) begin
                tx_d    = parity_q;
                state_d = PARITY;
              end else begin
                tx_d     = 1'b1;
                sb_cnt_d = '0;
                state_d  = STOP;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
              tx_d      = shreg_q[1];
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        PARITY: begin
          if (bit_last) begin
            tick_cnt_d = '0;
            tx_d       = 1'b1;
            sb_cnt_d   = '0;
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        STOP: begin
          if (sb_cnt_q == SBW'(SB_TICK - 1)) begin
            done_d = 1'b1;
            // A queued byte starts its start bit on this same tick, leaving no idle gap.
            if (buf_full_q) begin
              consume = 1'b1;
            end else begin
              tx_d    = 1'b1;
              state_d = IDLE;
            end
          end else begin
            sb_cnt_d = sb_cnt_q + SBW'(1);
          end
        end
        default: begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end
      endcase
    end

    if (consume) begin
      shreg_d    = buf_q;
      parity_d   = (^buf_q) ^ PAR_ODD;
      buf_full_d = 1'b0;
      tx_d       = 1'b0;
      tick_cnt_d = '0;
      state_d    = START;
    end

    // Load and consume are mutually exclusive: tx_ready is only high while the buffer is empty.
    if (load) begin
      buf_d      = din;
      buf_full_d = 1'b1;
    end
    tx_ready_d = load ? 1'b0 : !buf_full_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      sb_cnt_q   <= '0;
      shreg_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sb_cnt_q   <= sb_cnt_d;
      shreg_q    <= shreg_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
      done_q     <= done_d;
    end
  end

  assign tx           = tx_q;
  assign tx_ready     = tx_ready_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: 8N1 instance decoded by a line receiver model against a byte scoreboard,
// plus even/odd parity instances checked bit by bit.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int FRAME_TICKS = 160;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] din = '0;
  logic       tx_ready, tx, tx_done_tick;

  logic       tx_start_p = 1'b0;
  logic [7:0] din_p = '0;
  logic       rdy_pe, tx_pe, done_pe;
  logic       rdy_po, tx_po, done_po;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] sb_q[$];
  int         done_times[$];

  int         mon_idx = 0;
  bit         mon_active = 1'b0;
  bit         mon_glitch = 1'b0;
  logic [9:0] mon_bits = '0;
  logic [9:0] last_bits = '0;
  int         done_count = 0;
  int         frames_done = 0;
  int         b2b_count = 0;
  int         tick_total = 0;

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx_ready(tx_ready), .tx(tx), .tx_done_tick(tx_done_tick)
  );

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start_p), .din(din_p),
    .tx_ready(rdy_pe), .tx(tx_pe), .tx_done_tick(done_pe)
  );

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start_p), .din(din_p),
    .tx_ready(rdy_po), .tx(tx_po), .tx_done_tick(done_po)
  );

  always #5 clk = ~clk;

  // s_tick: one clk wide, every 4th clk
  initial begin
    int unsigned div;
    div = 0;
    forever begin
      @(negedge clk);
      div++;
      s_tick = (div % 4 == 0);
    end
  end

  // Line receiver model for the 8N1 instance
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(posedge clk); #1;
      if (tx_done_tick === 1'b1) done_count++;
      if (reset) begin
        mon_active = 1'b0;
      end else if (s_tick) begin
        tick_total++;
        if (mon_active && mon_idx == FRAME_TICKS) begin
          frames_done++;
          done_times.push_back(tick_total);
          last_bits = mon_bits;
          vectors++;
          if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL rx_byte: got frame %h, required no frame", mon_bits[8:1]);
          end else begin
            exp_b = sb_q.pop_front();
            if (mon_bits[8:1] !== exp_b) begin
              miscompares++;
              $display("FAIL rx_byte: got %h, required %h", mon_bits[8:1], exp_b);
            end
          end
          vectors++;
          if ({mon_glitch, mon_bits[0], mon_bits[9], tx_done_tick} !== 4'b0011) begin
            miscompares++;
            $display("FAIL rx_framing: {glitch,start,stop,done} got %b, required 0011",
                     {mon_glitch, mon_bits[0], mon_bits[9], tx_done_tick});
          end
          mon_active = 1'b0;
          if (tx === 1'b0) b2b_count++;
        end
        if (!mon_active && tx === 1'b0) begin
          mon_active = 1'b1;
          mon_idx    = 0;
          mon_glitch = 1'b0;
        end
        if (mon_active) begin
          if (mon_idx % 16 == 0) mon_bits[mon_idx / 16] = tx;
          else if (tx !== mon_bits[mon_idx / 16]) mon_glitch = 1'b1;
          mon_idx++;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  task automatic next_tick();
    do begin
      @(posedge clk); #1;
    end while (s_tick !== 1'b1);
  endtask

  task automatic load_byte(input logic [7:0] b, input bit push, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = (tx_ready === 1'b1);
    if (ok) begin
      if (push) sb_q.push_back(b);
      tx_start = 1'b1;
      din      = b;
      @(negedge clk);
      tx_start = 1'b0;
    end
  endtask

  task automatic wait_fall(input bit parity_dut, output bit ok);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((parity_dut ? tx_pe : tx) !== 1'b0 && n < 200);
    ok = ((parity_dut ? tx_pe : tx) === 1'b0);
  endtask

  task automatic wait_drain(input int max_clk, output bit ok);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || mon_active) && n < max_clk) begin
      @(negedge clk);
      n++;
    end
    ok = (sb_q.size() == 0 && !mon_active);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    vectors++;
    if ({tx, tx_ready, tx_done_tick} !== 3'b110) begin
      miscompares++;
      $display("FAIL reset_main: {tx,ready,done} got %b, required 110", {tx, tx_ready, tx_done_tick});
    end
    vectors++;
    if ({tx_pe, rdy_pe, done_pe, tx_po, rdy_po, done_po} !== 6'b110110) begin
      miscompares++;
      $display("FAIL reset_parity: got %b, required 110110",
               {tx_pe, rdy_pe, done_pe, tx_po, rdy_po, done_po});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_idle();
    int d0;
    d0 = done_count;
    repeat (50) begin
      next_tick();
      vectors++;
      if ({tx, tx_ready, tx_done_tick} !== 3'b110) begin
        miscompares++;
        $display("FAIL idle: {tx,ready,done} got %b, required 110", {tx, tx_ready, tx_done_tick});
      end
    end
    @(negedge clk);
    vectors++;
    if (done_count != d0) begin
      miscompares++;
      $display("FAIL idle_done: got %0d pulses, required 0", done_count - d0);
    end
  endtask

  task automatic test_8n1();
    bit ok;
    load_byte(8'hA5, 1'b1, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL 8n1_load: got ready=0, required 1"); end
    wait_fall(1'b0, ok);
    vectors++;
    if (!ok || tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL 8n1_fall: got fall=%0b ready=%b, required fall=1 ready=0", ok, tx_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL 8n1_ready_return: got %b, required 1", tx_ready);
    end
    wait_drain(2000, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL 8n1_drain: got timeout, required frame end"); end
    vectors++;
    if (last_bits !== 10'b1101001010) begin
      miscompares++;
      $display("FAIL 8n1_bits: got %b, required 1101001010 (bit9..bit0)", last_bits);
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, okd;
    int b0, n0;
    b0 = b2b_count;
    n0 = done_times.size();
    load_byte(8'h55, 1'b1, ok1);
    load_byte(8'hAA, 1'b1, ok2);
    vectors++;
    if (!(ok1 && ok2)) begin
      miscompares++;
      $display("FAIL b2b_load: got ok=%0b%0b, required 11", ok1, ok2);
    end
    wait_drain(4000, okd);
    vectors++;
    if (!okd || b2b_count - b0 != 1) begin
      miscompares++;
      $display("FAIL b2b_contiguous: got drained=%0b joins=%0d, required 1 and 1", okd, b2b_count - b0);
    end
    vectors++;
    if (done_times.size() - n0 != 2 ||
        done_times[done_times.size()-1] - done_times[done_times.size()-2] != FRAME_TICKS) begin
      miscompares++;
      $display("FAIL b2b_done_spacing: got %0d pulses, required 2 pulses %0d ticks apart",
               done_times.size() - n0, FRAME_TICKS);
    end
  endtask

  task automatic test_parity();
    bit ok;
    int b;
    logic [10:0] exp_e, exp_o;
    exp_e = {1'b1, 1'b1, 8'h07, 1'b0};
    exp_o = {1'b1, 1'b0, 8'h07, 1'b0};
    @(negedge clk);
    tx_start_p = 1'b1;
    din_p      = 8'h07;
    @(negedge clk);
    tx_start_p = 1'b0;
    wait_fall(1'b1, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL parity_fall: got no start bit, required one"); end
    for (int i = 0; i <= 176; i++) begin
      if (i % 16 == 8 && i < 176) begin
        b = i / 16;
        vectors++;
        if ({tx_pe, tx_po} !== {exp_e[b], exp_o[b]}) begin
          miscompares++;
          $display("FAIL parity_bit%0d: {even,odd} got %b%b, required %b%b",
                   b, tx_pe, tx_po, exp_e[b], exp_o[b]);
        end
      end
      if (i == 160) begin
        vectors++;
        if ({done_pe, done_po} !== 2'b00) begin
          miscompares++;
          $display("FAIL parity_early_done: got %b%b at tick 160, required 00", done_pe, done_po);
        end
      end
      if (i == 176) begin
        vectors++;
        if ({done_pe, done_po} !== 2'b11) begin
          miscompares++;
          $display("FAIL parity_done: got %b%b at tick 176, required 11", done_pe, done_po);
        end
      end
      if (i < 176) next_tick();
    end
  endtask

  task automatic test_ignore();
    bit ok, okd;
    int f0;
    f0 = frames_done;
    load_byte(8'h11, 1'b1, ok);
    vectors++;
    if (!ok || tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_setup: got load=%0b ready=%b, required load=1 ready=0", ok, tx_ready);
    end
    tx_start = 1'b1;
    din      = 8'h3C;
    @(negedge clk);
    tx_start = 1'b0;
    wait_drain(2000, okd);
    repeat (200) next_tick();
    @(negedge clk);
    vectors++;
    if (!okd || frames_done - f0 != 1 || tx !== 1'b1 || tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ignore_frames: got drained=%0b frames=%0d tx=%b ready=%b, required 1 1 1 1",
               okd, frames_done - f0, tx, tx_ready);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, okd;
    int d0, f0;
    d0 = done_count;
    load_byte(8'hF0, 1'b0, ok);
    wait_fall(1'b0, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL abort_fall: got no start bit, required one"); end
    repeat (70) next_tick();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({tx, tx_ready, tx_done_tick} !== 3'b110) begin
      miscompares++;
      $display("FAIL abort_state: {tx,ready,done} got %b, required 110", {tx, tx_ready, tx_done_tick});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (200) next_tick();
    @(negedge clk);
    vectors++;
    if (done_count != d0 || tx !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_quiet: got pulses=%0d tx=%b, required 0 and 1", done_count - d0, tx);
    end
    f0 = frames_done;
    load_byte(8'h81, 1'b1, ok);
    wait_drain(2000, okd);
    vectors++;
    if (!(ok && okd) || frames_done - f0 != 1) begin
      miscompares++;
      $display("FAIL abort_recover: got load=%0b drained=%0b frames=%0d, required 1 1 1",
               ok, okd, frames_done - f0);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_8n1();
    test_back_to_back();
    test_parity();
    test_ignore();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
